// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single Dcache port between DMMU PTW, IMMU PTW and CPU LSU.
// One locked transaction at a time, registered request, one-cycle DONE handshake.
module dcache_port_arbiter #(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int CPU_WAIT_MAX = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dmmu_ren,
    input  logic [ADDR_WIDTH-1:0]   dmmu_addr,
    output logic [DATA_WIDTH-1:0]   dmmu_rdata,
    output logic                    dmmu_stall,
    input  logic                    immu_ren,
    input  logic [ADDR_WIDTH-1:0]   immu_addr,
    output logic [DATA_WIDTH-1:0]   immu_rdata,
    output logic                    immu_stall,
    input  logic                    cpu_ren,
    input  logic                    cpu_wen,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_wmask,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_stall,
    output logic                    cache_ren,
    output logic                    cache_wen,
    output logic [ADDR_WIDTH-1:0]   cache_addr,
    output logic [DATA_WIDTH-1:0]   cache_wdata,
    output logic [DATA_WIDTH/8-1:0] cache_wmask,
    input  logic [DATA_WIDTH-1:0]   cache_rdata,
    input  logic                    cache_stall
);

    localparam int MW = DATA_WIDTH / 8;
    localparam int WW = $clog2(CPU_WAIT_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_DMMU, OWN_IMMU, OWN_CPU} owner_t;

    state_t                state;
    owner_t                owner;
    owner_t                grant;
    logic                  rr_last_immu;
    logic [WW-1:0]         cpu_wait;
    logic                  ren_q;
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [MW-1:0]         wmask_q;
    logic                  cpu_req;
    logic                  cpu_force;

    assign cpu_req   = cpu_ren | cpu_wen;
    assign cpu_force = cpu_req && (cpu_wait >= WW'(CPU_WAIT_MAX));

    always_comb begin
        grant = OWN_NONE;
        if (cpu_force)
            grant = OWN_CPU;
        else if (dmmu_ren && immu_ren)
            grant = rr_last_immu ? OWN_DMMU : OWN_IMMU;
        else if (dmmu_ren)
            grant = OWN_DMMU;
        else if (immu_ren)
            grant = OWN_IMMU;
        else if (cpu_req)
            grant = OWN_CPU;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= OWN_NONE;
            rr_last_immu <= 1'b1;
            cpu_wait     <= '0;
            ren_q        <= 1'b0;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            dmmu_rdata   <= '0;
            immu_rdata   <= '0;
            cpu_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != OWN_NONE) begin
                        owner <= grant;
                        state <= BUSY;
                        case (grant)
                            OWN_DMMU: begin
                                addr_q       <= dmmu_addr;
                                ren_q        <= 1'b1;
                                wen_q        <= 1'b0;
                                wdata_q      <= '0;
                                wmask_q      <= '0;
                                rr_last_immu <= 1'b0;
                            end
                            OWN_IMMU: begin
                                addr_q       <= immu_addr;
                                ren_q        <= 1'b1;
                                wen_q        <= 1'b0;
                                wdata_q      <= '0;
                                wmask_q      <= '0;
                                rr_last_immu <= 1'b1;
                            end
                            default: begin
                                addr_q  <= cpu_addr;
                                ren_q   <= cpu_ren;
                                wen_q   <= cpu_wen;
                                wdata_q <= cpu_wdata;
                                wmask_q <= cpu_wmask;
                            end
                        endcase
                    end
                end
                BUSY: begin
                    if (!cache_stall) begin
                        ren_q <= 1'b0;
                        wen_q <= 1'b0;
                        state <= DONE;
                        case (owner)
                            OWN_DMMU: dmmu_rdata <= cache_rdata;
                            OWN_IMMU: immu_rdata <= cache_rdata;
                            OWN_CPU:  if (ren_q) cpu_rdata <= cache_rdata;
                            default:  ;
                        endcase
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= OWN_NONE;
                end
            endcase

            // Starvation counter: saturates, cleared by a CPU grant or an idle CPU
            if (!cpu_req || (state == IDLE && grant == OWN_CPU))
                cpu_wait <= '0;
            else if (owner != OWN_CPU && cpu_wait < WW'(CPU_WAIT_MAX))
                cpu_wait <= cpu_wait + 1'b1;
        end
    end

    assign dmmu_stall  = dmmu_ren && !(state == DONE && owner == OWN_DMMU);
    assign immu_stall  = immu_ren && !(state == DONE && owner == OWN_IMMU);
    assign cpu_stall   = cpu_req  && !(state == DONE && owner == OWN_CPU);

    assign cache_ren   = ren_q;
    assign cache_wen   = wen_q;
    assign cache_addr  = addr_q;
    assign cache_wdata = wdata_q;
    assign cache_wmask = wmask_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: per-cycle vector table plus
// hand-written store-stall, mid-transaction reset and CPU starvation sequences.
module tb_dcache_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmmu_ren, immu_ren, cpu_ren, cpu_wen;
    logic [63:0] dmmu_addr, immu_addr, cpu_addr, cpu_wdata;
    logic [7:0]  cpu_wmask;
    logic [63:0] dmmu_rdata, immu_rdata, cpu_rdata;
    logic        dmmu_stall, immu_stall, cpu_stall;
    logic        cache_ren, cache_wen;
    logic [63:0] cache_addr, cache_wdata, cache_rdata;
    logic [7:0]  cache_wmask;
    logic        cache_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .CPU_WAIT_MAX(8)
    ) dut (
        .clk(clk), .rst(rst),
        .dmmu_ren(dmmu_ren), .dmmu_addr(dmmu_addr),
        .dmmu_rdata(dmmu_rdata), .dmmu_stall(dmmu_stall),
        .immu_ren(immu_ren), .immu_addr(immu_addr),
        .immu_rdata(immu_rdata), .immu_stall(immu_stall),
        .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .cache_ren(cache_ren), .cache_wen(cache_wen),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata),
        .cache_wmask(cache_wmask), .cache_rdata(cache_rdata),
        .cache_stall(cache_stall)
    );

    typedef struct {
        logic        d;
        logic        i;
        logic        c;
        logic [63:0] crd;
        logic        e_ren;
        logic        e_ds;
        logic        e_is;
        logic        e_cs;
        logic [63:0] e_addr;
        logic        chk_addr;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 3 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int gcyc[8];
    logic [63:0] gaddr[8];
    int ecyc[8];
    logic [63:0] eaddr[8];
    int n;
    logic prev_ren;

    initial begin
        vt[0]  = '{1'b0, 1'b0, 1'b1, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'h0,        1'b0};
        vt[1]  = '{1'b0, 1'b0, 1'b1, 64'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 64'h80001000, 1'b1};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 64'h0,        1'b0, 1'b0, 1'b0, 1'b0, 64'h0,        1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b0, 64'h0,        1'b0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 64'h0,        1'b0, 1'b1, 1'b1, 1'b0, 64'h0,        1'b0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 64'hD1D1,     1'b1, 1'b1, 1'b1, 1'b0, 64'h1000,     1'b1};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 1'b1, 1'b0, 64'h0,        1'b0};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 64'h0,        1'b0, 1'b1, 1'b1, 1'b0, 64'h0,        1'b0};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 64'h1111,     1'b1, 1'b1, 1'b1, 1'b0, 64'h2000,     1'b1};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 64'h0,        1'b0, 1'b1, 1'b0, 1'b0, 64'h0,        1'b0};
        vt[10] = '{1'b1, 1'b1, 1'b0, 64'h0,        1'b0, 1'b1, 1'b1, 1'b0, 64'h0,        1'b0};
        vt[11] = '{1'b1, 1'b1, 1'b0, 64'hD2D2,     1'b1, 1'b1, 1'b1, 1'b0, 64'h1000,     1'b1};
        vt[12] = '{1'b1, 1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 1'b1, 1'b0, 64'h0,        1'b0};
        vt[13] = '{1'b1, 1'b1, 1'b0, 64'h0,        1'b0, 1'b1, 1'b1, 1'b0, 64'h0,        1'b0};
        vt[14] = '{1'b1, 1'b1, 1'b0, 64'h2222,     1'b1, 1'b1, 1'b1, 1'b0, 64'h2000,     1'b1};
        vt[15] = '{1'b1, 1'b1, 1'b0, 64'h0,        1'b0, 1'b1, 1'b0, 1'b0, 64'h0,        1'b0};
        vt[16] = '{1'b0, 1'b0, 1'b0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b0, 64'h0,        1'b0};

        rst = 1'b1;
        dmmu_ren = 0; immu_ren = 0; cpu_ren = 0; cpu_wen = 0;
        dmmu_addr = 64'h1000; immu_addr = 64'h2000;
        cpu_addr = 64'h80001000; cpu_wdata = '0; cpu_wmask = '0;
        cache_rdata = '0; cache_stall = 1'b0;

        // Reset, then 20 idle cycles
        repeat (2) next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            #3;
            chk("idle_quiet",
                {59'd0, cache_ren, cache_wen, dmmu_stall, immu_stall, cpu_stall},
                64'd0);
        end
        chk("rst_dmmu_rdata", dmmu_rdata, 64'd0);
        chk("rst_immu_rdata", immu_rdata, 64'd0);
        chk("rst_cpu_rdata", cpu_rdata, 64'd0);

        // Vector table: CPU load, then alternating dual MMU requests
        for (int k = 0; k < 17; k++) begin
            next_cycle();
            dmmu_ren = vt[k].d;
            immu_ren = vt[k].i;
            cpu_ren  = vt[k].c;
            cache_rdata = vt[k].crd;
            #3;
            chk($sformatf("v%0d_cache_ren", k), 64'(cache_ren), 64'(vt[k].e_ren));
            chk($sformatf("v%0d_cache_wen", k), 64'(cache_wen), 64'd0);
            chk($sformatf("v%0d_dmmu_stall", k), 64'(dmmu_stall), 64'(vt[k].e_ds));
            chk($sformatf("v%0d_immu_stall", k), 64'(immu_stall), 64'(vt[k].e_is));
            chk($sformatf("v%0d_cpu_stall", k), 64'(cpu_stall), 64'(vt[k].e_cs));
            if (vt[k].chk_addr)
                chk($sformatf("v%0d_cache_addr", k), cache_addr, vt[k].e_addr);
            if (k == 2)
                chk("load_cpu_rdata", cpu_rdata, 64'hDEADBEEF);
        end
        chk("tbl_dmmu_rdata", dmmu_rdata, 64'hD2D2);
        chk("tbl_immu_rdata", immu_rdata, 64'h2222);
        chk("tbl_cpu_rdata", cpu_rdata, 64'hDEADBEEF);

        // CPU store with 5 stall cycles
        next_cycle();
        cpu_wen = 1'b1; cpu_addr = 64'h80002000;
        cpu_wdata = 64'h1122334455667788; cpu_wmask = 8'h0F;
        #3;
        chk("st_req_stall", 64'(cpu_stall), 64'd1);
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            cache_stall = (k < 6);
            cache_rdata = 64'hBAD0BAD0;
            #3;
            chk($sformatf("st_b%0d_wen", k), 64'(cache_wen), 64'd1);
            chk($sformatf("st_b%0d_ren", k), 64'(cache_ren), 64'd0);
            chk($sformatf("st_b%0d_addr", k), cache_addr, 64'h80002000);
            chk($sformatf("st_b%0d_wdata", k), cache_wdata, 64'h1122334455667788);
            chk($sformatf("st_b%0d_wmask", k), 64'(cache_wmask), 64'h0F);
            chk($sformatf("st_b%0d_stall", k), 64'(cpu_stall), 64'd1);
        end
        next_cycle();
        #3;
        chk("st_done_stall", 64'(cpu_stall), 64'd0);
        chk("st_done_wen", 64'(cache_wen), 64'd0);
        chk("st_cpu_rdata", cpu_rdata, 64'hDEADBEEF);
        next_cycle();
        cpu_wen = 1'b0; cache_stall = 1'b0; cache_rdata = '0;
        #3;
        chk("st_idle_stall", 64'(cpu_stall), 64'd0);

        // Reset during the 2nd BUSY cycle of an IMMU read
        next_cycle();
        immu_ren = 1'b1; cache_stall = 1'b1;
        #3;
        chk("rs_req_stall", 64'(immu_stall), 64'd1);
        next_cycle();
        #3;
        chk("rs_b1_ren", 64'(cache_ren), 64'd1);
        next_cycle();
        rst = 1'b1;
        #3;
        chk("rs_b2_ren", 64'(cache_ren), 64'd1);
        next_cycle();
        rst = 1'b0; cache_stall = 1'b0; cache_rdata = 64'h5A5A;
        #3;
        chk("rs_after_ren", 64'(cache_ren), 64'd0);
        chk("rs_after_stall", 64'(immu_stall), 64'd1);
        next_cycle();
        #3;
        chk("rs_regrant_ren", 64'(cache_ren), 64'd1);
        chk("rs_regrant_addr", cache_addr, 64'h2000);
        next_cycle();
        #3;
        chk("rs_done_stall", 64'(immu_stall), 64'd0);
        chk("rs_done_rdata", immu_rdata, 64'h5A5A);
        chk("rs_done_ren", 64'(cache_ren), 64'd0);
        next_cycle();
        immu_ren = 1'b0;

        // CPU starvation bound with all three requesting continuously
        rst = 1'b1;
        repeat (2) next_cycle();
        rst = 1'b0;
        ecyc  = '{1, 4, 7, 10, 13, 16, 19, 22};
        eaddr = '{64'h1000, 64'h2000, 64'h1000, 64'h80003000,
                  64'h2000, 64'h1000, 64'h2000, 64'h80003000};
        for (int k = 0; k < 8; k++) begin
            gcyc[k]  = -1;
            gaddr[k] = '0;
        end
        n = 0;
        prev_ren = 1'b0;
        next_cycle();
        dmmu_ren = 1'b1; immu_ren = 1'b1; cpu_ren = 1'b1;
        cpu_addr = 64'h80003000; cache_rdata = 64'h77;
        for (int cyc = 0; cyc < 25; cyc++) begin
            #3;
            if (cache_ren && !prev_ren && n < 8) begin
                gcyc[n]  = cyc;
                gaddr[n] = cache_addr;
                n++;
            end
            prev_ren = cache_ren;
            next_cycle();
        end
        dmmu_ren = 1'b0; immu_ren = 1'b0; cpu_ren = 1'b0;
        chk("sv_grant_count", 64'(n), 64'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("sv_g%0d_cycle", k), 64'(gcyc[k]), 64'(ecyc[k]));
            chk($sformatf("sv_g%0d_addr", k), gaddr[k], eaddr[k]);
        end
        chk("sv_cpu_rdata", cpu_rdata, 64'h77);

        repeat (3) next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
